pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter sequencer for the core's fetch stage.
- Owns the PC register and a runtime-writable 16-entry branch-target table, which replaces the fixed target LUT.
- Each cycle it selects one of: increment, absolute jump, PC-relative branch, stall, or halt.
- The table is loaded through a config port while the core is idle. Fetch consumes pc and fetch_valid.

Parameters:
- D, 10, PC and target-table entry width in bits.
- N_ENT, 16, number of target-table entries; index width is log2(N_ENT)=4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin or restart execution (IDLE/DONE -> RUN).
- halt_req  in  1  program-end request from decode.
- stall  in  1  hold PC this cycle (hazard or memory wait).
- br_en  in  1  current instruction is a branch/jump.
- br_taken  in  1  branch condition true; ignored unless br_en.
- br_rel  in  1  1 = PC-relative (pc + entry); 0 = absolute (entry).
- br_idx  in  4  target-table index.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  4  table write index.
- cfg_data  in  D  table write data.
- pc  out  D  current program counter.
- fetch_valid  out  1  pc is a live fetch address this cycle.
- done  out  1  program halted.
- cfg_err  out  1  one-cycle pulse: write attempted while in RUN.

Behaviour:
- Reset (async, any state, including mid-RUN):
  - pc=0, state=IDLE, done=0, cfg_err=0.
  - All table entries cleared to 0.
  - fetch_valid=0 combinationally while reset is high.
- States: IDLE, RUN, DONE. fetch_valid = (state==RUN) && !stall, combinational.
- IDLE:
  - pc holds.
  - cfg_we writes table[cfg_addr] <= cfg_data at the clock edge.
  - start=1 -> RUN with pc=0.
- RUN, next-PC priority, registered at each edge:
  1. halt_req=1 -> DONE; pc holds. halt_req wins over stall and branch in the same cycle.
  2. stall=1 -> pc holds; stay in RUN. br_en is ignored.
  3. br_en && br_taken && !br_rel -> pc <= table[br_idx].
  4. br_en && br_taken && br_rel -> pc <= (pc + table[br_idx]) mod 2^D.
     - The entry is two's complement, so 0x3FF = -1 and 0x3FB = -5.
     - The carry out is discarded; the result wraps with no error flag.
  5. Otherwise -> pc <= (pc + 1) mod 2^D. pc=2^D-1 wraps to 0.
- Branch latency: target visible on pc the cycle after br_en is sampled; no delay slot.
- The table read in RUN is combinational on br_idx.
- DONE:
  - done=1, registered, asserted from the first DONE cycle; pc holds its final value.
  - Config writes accepted as in IDLE.
  - start=1 -> RUN with pc=0, done=0 next cycle.
- Config writes in RUN:
  - Table unchanged.
  - cfg_err=1 for exactly the following cycle, then 0.
  - Back-to-back illegal writes keep cfg_err high on consecutive cycles.
- A write and a branch lookup to the same index cannot coincide, because writes are accepted only outside RUN.
- start in RUN is ignored.
- All outputs are registered except fetch_valid.

Test Plan:
- Reset, then IDLE; write table[1]=11, table[2]=80; start; run 3 cycles with no branch -> pc sequence 0,1,2,3; fetch_valid=1 each cycle.
- At pc=3, br_en=1, br_taken=1, br_rel=0, br_idx=2 -> pc=80 next cycle. Repeat with br_taken=0 -> pc=81.
- Relative branches:
  - table[9]=0x3FB (-5) at pc=20, br_rel=1 -> pc=15.
  - table[9]=0x3FF at pc=4 -> pc=3.
  - table[9]=20 at pc=1020 -> pc=16 (wrap).
- stall=1 for 2 cycles with br_en=1 asserted -> pc frozen and fetch_valid=0 both cycles; branch not taken.
- Halt and restart:
  - halt_req and stall together at pc=40 -> DONE, done=1, pc stays 40.
  - start -> pc=0, done=0, RUN.
- Config misuse and reset:
  - cfg_we in RUN to index 5 -> cfg_err pulses 1 cycle; a later absolute jump via idx 5 still yields the old value.
  - Assert reset mid-RUN at pc=57 -> pc=0, IDLE, table all 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program-counter sequencer with runtime-loadable branch-target table
// Chooses increment, absolute jump, PC-relative branch, stall or halt each cycle.
module pc_sequencer #(
    parameter int D     = 10,
    parameter int N_ENT = 16,
    localparam int IW   = $clog2(N_ENT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          halt_req,
    input  logic          stall,
    input  logic          br_en,
    input  logic          br_taken,
    input  logic          br_rel,
    input  logic [IW-1:0] br_idx,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_addr,
    input  logic [D-1:0]  cfg_data,
    output logic [D-1:0]  pc,
    output logic          fetch_valid,
    output logic          done,
    output logic          cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       state;
    logic [D-1:0] tgt_tab [N_ENT];
    logic [D-1:0] tgt_entry;
    logic [D-1:0] pc_next_run;
    logic         branch_hit;

    // Table lookup is combinational; the table never changes while in RUN,
    // so there is no read/write ordering hazard on the same index.
    assign tgt_entry  = tgt_tab[br_idx];
    assign branch_hit = br_en && br_taken;

    always_comb begin
        pc_next_run = pc + {{(D-1){1'b0}}, 1'b1};
        if (branch_hit) begin
            // Relative targets are two's complement; the carry out drops naturally.
            if (br_rel)
                pc_next_run = pc + tgt_entry;
            else
                pc_next_run = tgt_entry;
        end
    end

    assign fetch_valid = (state == S_RUN) && !stall && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            pc      <= '0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
            for (int i = 0; i < N_ENT; i++)
                tgt_tab[i] <= '0;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (cfg_we)
                        tgt_tab[cfg_addr] <= cfg_data;
                    if (start) begin
                        state <= S_RUN;
                        pc    <= '0;
                        done  <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Writes are refused while running; flag the attempt for one cycle.
                    cfg_err <= cfg_we;
                    if (halt_req) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (!stall) begin
                        pc <= pc_next_run;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized self-checking bench for pc_sequencer
// A mode/PC/table model is advanced per clock and compared every negedge.
module tb_pc_sequencer;

    localparam int D = 10;
    localparam int MASK = (1 << D) - 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       halt_req = 1'b0;
    logic       stall = 1'b0;
    logic       br_en = 1'b0;
    logic       br_taken = 1'b0;
    logic       br_rel = 1'b0;
    logic [3:0] br_idx = '0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [9:0] cfg_data = '0;
    logic [9:0] pc;
    logic       fetch_valid;
    logic       done;
    logic       cfg_err;

    pc_sequencer #(.D(10), .N_ENT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .stall(stall), .br_en(br_en), .br_taken(br_taken), .br_rel(br_rel),
        .br_idx(br_idx), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .pc(pc), .fetch_valid(fetch_valid), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Model: mode 0 = idle, 1 = running, 2 = halted.
    int m_mode;
    int m_pc;
    int m_err;
    int m_tab [16];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc = 0;
        m_err = 0;
        for (int i = 0; i < 16; i++) m_tab[i] = 0;
    endtask

    task automatic clear_inputs();
        start = 0; halt_req = 0; stall = 0; br_en = 0; br_taken = 0;
        br_rel = 0; br_idx = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
    endtask

    // One clock: compare at negedge, advance the model across the posedge.
    task automatic tick();
        int n_mode, n_pc, n_err;
        @(negedge clk);
        chk("pc", int'(pc), m_pc);
        chk("done", int'(done), (m_mode == 2) ? 1 : 0);
        chk("cfg_err", int'(cfg_err), m_err);
        chk("fetch_valid", int'(fetch_valid), (m_mode == 1 && !stall && !reset) ? 1 : 0);
        n_mode = m_mode; n_pc = m_pc; n_err = 0;
        if (m_mode == 1) begin
            n_err = cfg_we ? 1 : 0;
            if (halt_req) n_mode = 2;
            else if (stall) n_pc = m_pc;
            else if (br_en && br_taken)
                n_pc = br_rel ? ((m_pc + m_tab[br_idx]) & MASK) : m_tab[br_idx];
            else n_pc = (m_pc + 1) & MASK;
        end else begin
            if (cfg_we) m_tab[cfg_addr] = int'(cfg_data);
            if (start) begin n_mode = 1; n_pc = 0; end
        end
        @(posedge clk);
        m_mode = n_mode; m_pc = n_pc; m_err = n_err;
        #1;
    endtask

    task automatic wr(input int a, input int d);
        clear_inputs(); cfg_we = 1; cfg_addr = 4'(a); cfg_data = 10'(d); tick(); clear_inputs();
    endtask

    task automatic go();
        clear_inputs(); start = 1; tick(); clear_inputs();
    endtask

    task automatic br(input bit rel, input bit taken, input int idx);
        clear_inputs(); br_en = 1; br_taken = taken; br_rel = rel; br_idx = 4'(idx); tick(); clear_inputs();
    endtask

    task automatic halt();
        clear_inputs(); halt_req = 1; tick(); clear_inputs();
    endtask

    task automatic do_reset();
        reset = 1;
        model_reset();
        #1;
        chk("rst_pc", int'(pc), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_fetch_valid", int'(fetch_valid), 0);
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    initial begin
        model_reset();
        clear_inputs();
        #1 reset = 1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Directed sequence
        wr(1, 11); wr(2, 80);
        go();
        tick(); tick(); tick();
        chk("lit_pc3", int'(pc), 3);
        br(0, 1, 2);
        chk("lit_abs80", int'(pc), 80);
        br(0, 0, 2);
        chk("lit_nt81", int'(pc), 81);
        halt();
        chk("lit_done", int'(done), 1);
        wr(9, 10'h3FB); wr(3, 20); wr(4, 4); wr(6, 1020); wr(7, 40); wr(5, 33);
        go();
        br(0, 1, 3); br(1, 1, 9);
        chk("lit_rel_m5", int'(pc), 15);
        halt(); wr(9, 10'h3FF); go();
        br(0, 1, 4); br(1, 1, 9);
        chk("lit_rel_m1", int'(pc), 3);
        halt(); wr(9, 20); go();
        br(0, 1, 6); br(1, 1, 9);
        chk("lit_rel_wrap", int'(pc), 16);
        clear_inputs(); stall = 1; br_en = 1; br_taken = 1; br_idx = 2;
        #1 chk("lit_stall_fv", int'(fetch_valid), 0);
        tick(); tick();
        chk("lit_stall_pc", int'(pc), 16);
        clear_inputs(); tick();
        chk("lit_after_stall", int'(pc), 17);
        br(0, 1, 7);
        clear_inputs(); halt_req = 1; stall = 1; tick(); clear_inputs();
        chk("lit_halt_done", int'(done), 1);
        chk("lit_halt_pc", int'(pc), 40);
        tick();
        go();
        chk("lit_restart_pc", int'(pc), 0);
        chk("lit_restart_done", int'(done), 0);
        wr(5, 99);
        chk("lit_cfg_err", int'(cfg_err), 1);
        wr(5, 98); wr(5, 97);
        chk("lit_cfg_err_b2b", int'(cfg_err), 1);
        tick();
        chk("lit_cfg_err_clr", int'(cfg_err), 0);
        br(0, 1, 5);
        chk("lit_old_entry", int'(pc), 33);

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            start    = ($urandom_range(0, 7) == 0);
            halt_req = ($urandom_range(0, 19) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            br_en    = ($urandom_range(0, 2) == 0);
            br_taken = $urandom_range(0, 1);
            br_rel   = $urandom_range(0, 1);
            br_idx   = 4'($urandom_range(0, 15));
            cfg_we   = ($urandom_range(0, 5) == 0);
            cfg_addr = 4'($urandom_range(0, 15));
            cfg_data = 10'($urandom_range(0, 1023));
            tick();
        end
        clear_inputs();

        // Reset mid-RUN at pc=57 clears everything immediately
        do_reset();
        wr(8, 57); go(); br(0, 1, 8);
        chk("lit_pc57", int'(pc), 57);
        do_reset();
        go();
        for (int i = 0; i < 16; i++) br(0, 1, i);
        chk("lit_tab_cleared", int'(pc), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
